// File: rtl/fir_ctrl_mc_if.sv
// rtl/fir_ctrl_mc_if.sv - issue/result bus between the FIR controller, its RAMs and the DSP58.
interface fir_ctrl_mc_if #(
  parameter int H_ADDR_WIDTH = 4,
  parameter int X_ADDR_WIDTH = 6,
  parameter int N_WIDTH      = 8,
  parameter int NUM_CH       = 2
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic                    start_i;
  logic [N_WIDTH-1:0]      n_out_i;
  logic [X_ADDR_WIDTH-1:0] x_base_i;
  logic                    fpopmode_bit_i;
  logic                    ovf_i;
  logic                    unf_i;
  logic                    inv_i;
  logic                    R_en;
  logic [H_ADDR_WIDTH-1:0] h_addr;
  logic [X_ADDR_WIDTH-1:0] x_addr;
  logic [CH_W-1:0]         ch_o;
  logic                    acc_first_o;
  logic                    acc_last_o;
  logic                    y_valid_o;
  logic [CH_W-1:0]         y_ch_o;
  logic                    busy_o;
  logic                    done_o;
  logic                    overflow_o;
  logic                    underflow_o;
  logic                    invalid_o;

  modport master (
    input  start_i, n_out_i, x_base_i, fpopmode_bit_i, ovf_i, unf_i, inv_i,
    output R_en, h_addr, x_addr, ch_o, acc_first_o, acc_last_o,
           y_valid_o, y_ch_o, busy_o, done_o, overflow_o, underflow_o, invalid_o
  );

  modport slave (
    output start_i, n_out_i, x_base_i, fpopmode_bit_i, ovf_i, unf_i, inv_i,
    input  R_en, h_addr, x_addr, ch_o, acc_first_o, acc_last_o,
           y_valid_o, y_ch_o, busy_o, done_o, overflow_o, underflow_o, invalid_o
  );
endinterface

// File: rtl/fir_ctrl_mc.sv
// rtl/fir_ctrl_mc.sv - multi-channel FIR read sequencer and DSP58 accumulator control.
module fir_ctrl_mc #(
  parameter int H_ADDR_WIDTH = 4,
  parameter int X_ADDR_WIDTH = 6,
  parameter int NUM_TAPS     = 16,
  parameter int NUM_CH       = 2,
  parameter int DSP_LAT      = 4,
  parameter int N_WIDTH      = 8
) (
  input logic clk,
  input logic rst,
  fir_ctrl_mc_if.master bus
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int R_W  = N_WIDTH + CH_W + 1;
  localparam logic [H_ADDR_WIDTH-1:0] K_LAST = H_ADDR_WIDTH'(NUM_TAPS - 1);
  localparam logic [CH_W-1:0]         C_LAST = CH_W'(NUM_CH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state;

  logic [N_WIDTH-1:0]      n_out_q, n_cnt, n_nx;
  logic [X_ADDR_WIDTH-1:0] x_base_q, x_nx;
  logic [H_ADDR_WIDTH-1:0] k_cnt, k_nx;
  logic [CH_W-1:0]         c_cnt, c_nx;
  logic                    fp_q, k_end, c_end, last_issue;

  logic                    r_en_q, first_q, last_q;
  logic [H_ADDR_WIDTH-1:0] h_q;
  logic [X_ADDR_WIDTH-1:0] x_q;
  logic [CH_W-1:0]         ch_q;

  logic [DSP_LAT-1:0]           vld_q;
  logic [DSP_LAT-1:0][CH_W-1:0] ych_q;
  logic [DSP_LAT:0]             vld_all;
  logic [DSP_LAT:0][CH_W-1:0]   ych_all;
  logic [R_W-1:0]               res_left;
  logic busy_q, done_q, ovf_q, unf_q, inv_q;

  // Next issue indices: tap innermost, then channel, then output sample.
  always_comb begin
    k_end      = (k_cnt == K_LAST);
    c_end      = (c_cnt == C_LAST);
    k_nx       = k_end ? '0 : k_cnt + 1'b1;
    c_nx       = k_end ? (c_end ? '0 : c_cnt + 1'b1) : c_cnt;
    n_nx       = (k_end && c_end) ? n_cnt + 1'b1 : n_cnt;
    last_issue = k_end && c_end && (n_cnt == n_out_q - N_WIDTH'(1));
    x_nx       = x_base_q + X_ADDR_WIDTH'(n_nx) - X_ADDR_WIDTH'(k_nx);
    vld_all    = {vld_q, last_q};
    ych_all    = {ych_q, ch_q};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      n_out_q  <= '0;
      x_base_q <= '0;
      fp_q     <= 1'b0;
      n_cnt    <= '0;
      k_cnt    <= '0;
      c_cnt    <= '0;
      r_en_q   <= 1'b0;
      first_q  <= 1'b0;
      last_q   <= 1'b0;
      h_q      <= '0;
      x_q      <= '0;
      ch_q     <= '0;
      vld_q    <= '0;
      ych_q    <= '0;
      res_left <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      inv_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      vld_q  <= vld_all[DSP_LAT-1:0];
      ych_q  <= ych_all[DSP_LAT-1:0];
      if (vld_all[DSP_LAT] && fp_q) begin
        ovf_q <= ovf_q | bus.ovf_i;
        unf_q <= unf_q | bus.unf_i;
        inv_q <= inv_q | bus.inv_i;
      end
      if (done_q) busy_q <= 1'b0;

      case (state)
        IDLE: if (bus.start_i) begin
          n_out_q  <= bus.n_out_i;
          x_base_q <= bus.x_base_i;
          fp_q     <= bus.fpopmode_bit_i;
          ovf_q    <= 1'b0;
          unf_q    <= 1'b0;
          inv_q    <= 1'b0;
          n_cnt    <= '0;
          k_cnt    <= '0;
          c_cnt    <= '0;
          res_left <= R_W'(bus.n_out_i) * R_W'(NUM_CH);
          if (bus.n_out_i != '0) begin
            state   <= RUN;
            busy_q  <= 1'b1;
            r_en_q  <= 1'b1;
            first_q <= 1'b1;
            last_q  <= 1'b0;
            h_q     <= '0;
            x_q     <= bus.x_base_i;
            ch_q    <= '0;
          end else begin
            state  <= DRAIN;
            done_q <= 1'b1;
          end
        end
        RUN: if (last_issue) begin
          state   <= DRAIN;
          r_en_q  <= 1'b0;
          first_q <= 1'b0;
          last_q  <= 1'b0;
          h_q     <= '0;
          x_q     <= '0;
          ch_q    <= '0;
        end else begin
          k_cnt   <= k_nx;
          c_cnt   <= c_nx;
          n_cnt   <= n_nx;
          h_q     <= k_nx;
          x_q     <= x_nx;
          ch_q    <= c_nx;
          first_q <= (k_nx == '0);
          last_q  <= (k_nx == K_LAST);
        end
        DRAIN: if (res_left == '0) state <= IDLE;
        default: state <= IDLE;
      endcase

      // The last result entering the final pipeline stage ends the run.
      if (vld_all[DSP_LAT-1]) begin
        res_left <= res_left - R_W'(1);
        if (res_left == R_W'(1)) begin
          done_q <= 1'b1;
          state  <= IDLE;
        end
      end
    end
  end

  assign bus.R_en        = r_en_q;
  assign bus.h_addr      = h_q;
  assign bus.x_addr      = x_q;
  assign bus.ch_o        = ch_q;
  assign bus.acc_first_o = first_q;
  assign bus.acc_last_o  = last_q;
  assign bus.y_valid_o   = vld_all[DSP_LAT];
  assign bus.y_ch_o      = ych_all[DSP_LAT];
  assign bus.busy_o      = busy_q;
  assign bus.done_o      = done_q;
  assign bus.overflow_o  = ovf_q;
  assign bus.underflow_o = unf_q;
  assign bus.invalid_o   = inv_q;
endmodule

// File: tb/tb_fir_ctrl_mc.sv
// tb/tb_fir_ctrl_mc.sv - scoreboard bench for fir_ctrl_mc.
module tb_fir_ctrl_mc;
  localparam int HW = 4, XW = 6, NT = 16, NCH = 2, LAT = 4, NW = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fir_ctrl_mc_if #(.H_ADDR_WIDTH(HW), .X_ADDR_WIDTH(XW), .N_WIDTH(NW), .NUM_CH(NCH)) bus();

  fir_ctrl_mc #(.H_ADDR_WIDTH(HW), .X_ADDR_WIDTH(XW), .NUM_TAPS(NT), .NUM_CH(NCH),
                .DSP_LAT(LAT), .N_WIDTH(NW)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {int cyc; int h; int x; int ch; int first; int last;} iss_t;
  typedef struct {int cyc; int ch;} res_t;

  iss_t exp_iss[$];
  res_t exp_res[$];
  int   exp_done[$];
  bit   exp_yv[int];
  iss_t e;
  res_t r;
  int   cyc = 0;
  int   busy_lo = 1, busy_hi = 0;
  int   last_done_cyc = -1;
  int   exp_ovf, exp_unf, exp_inv;
  bit   fp_m;
  int   exc_mode = 0, ovf_at = -1, inv_at = -1;
  int   checks = 0, errors = 0;
  int   s;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d cycle=%0d", name, act, exp, cyc);
    end
  endfunction

  function automatic logic [31:0] all_outs();
    return {11'd0, bus.R_en, bus.h_addr, bus.x_addr, bus.ch_o, bus.acc_first_o, bus.acc_last_o,
            bus.y_valid_o, bus.y_ch_o, bus.busy_o, bus.done_o,
            bus.overflow_o, bus.underflow_o, bus.invalid_o};
  endfunction

  // Exception stimulus, with the model's view of which cycles carry a result.
  always @(posedge clk) begin
    #1;
    if (exc_mode == 0) begin
      bus.ovf_i = ($urandom_range(0, 7) == 0);
      bus.unf_i = ($urandom_range(0, 7) == 0);
      bus.inv_i = ($urandom_range(0, 7) == 0);
    end else begin
      bus.ovf_i = (exc_mode == 1) && (cyc == ovf_at);
      bus.unf_i = 1'b0;
      bus.inv_i = (exc_mode == 1) && (cyc == inv_at);
    end
    if (fp_m && exp_yv.exists(cyc)) begin
      exp_ovf |= int'(bus.ovf_i);
      exp_unf |= int'(bus.unf_i);
      exp_inv |= int'(bus.inv_i);
    end
  end

  // Monitor: pops expectations whenever the DUT presents an issue, result or done.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.R_en) begin
        if (exp_iss.size() == 0) chk("unexpected_issue", 1, 0);
        else begin
          e = exp_iss.pop_front();
          chk("issue_cycle", cyc, e.cyc);
          chk("h_addr", bus.h_addr, e.h);
          chk("x_addr", bus.x_addr, e.x);
          chk("ch_o", bus.ch_o, e.ch);
          chk("acc_first", bus.acc_first_o, e.first);
          chk("acc_last", bus.acc_last_o, e.last);
        end
      end else begin
        chk("idle_issue_outs", {bus.h_addr, bus.x_addr, bus.ch_o, bus.acc_first_o, bus.acc_last_o}, 0);
      end
      chk("busy", bus.busy_o, (cyc >= busy_lo && cyc <= busy_hi));
      if (bus.y_valid_o) begin
        if (exp_res.size() == 0) chk("unexpected_y_valid", 1, 0);
        else begin
          r = exp_res.pop_front();
          chk("y_valid_cycle", cyc, r.cyc);
          chk("y_ch", bus.y_ch_o, r.ch);
        end
      end
      if (bus.done_o) begin
        last_done_cyc = cyc;
        if (exp_done.size() == 0) chk("unexpected_done", 1, 0);
        else chk("done_cycle", cyc, exp_done.pop_front());
      end
    end
  end

  task automatic start_run(input int n, input int x, input bit fp, output int st);
    int idx = 0;
    int tot;
    @(posedge clk); #1;
    bus.start_i = 1'b1;
    bus.n_out_i = NW'(n);
    bus.x_base_i = XW'(x);
    bus.fpopmode_bit_i = fp;
    st = cyc;
    fp_m = fp;
    exp_ovf = 0; exp_unf = 0; exp_inv = 0;
    exp_yv.delete();
    for (int nn = 0; nn < n; nn++)
      for (int c = 0; c < NCH; c++)
        for (int k = 0; k < NT; k++) begin
          idx++;
          exp_iss.push_back('{st + idx, k, (((x + nn - k) % (1 << XW)) + (1 << XW)) % (1 << XW),
                              c, int'(k == 0), int'(k == NT - 1)});
          if (k == NT - 1) begin
            exp_res.push_back('{st + idx + LAT, c});
            exp_yv[st + idx + LAT] = 1'b1;
          end
        end
    tot = n * NCH * NT;
    if (n == 0) begin
      exp_done.push_back(st + 1);
      busy_lo = 1; busy_hi = 0;
    end else begin
      exp_done.push_back(st + tot + LAT);
      busy_lo = st + 1; busy_hi = st + tot + LAT;
    end
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    bus.n_out_i = NW'($urandom);
    bus.x_base_i = XW'($urandom);
    bus.fpopmode_bit_i = 1'($urandom);
  endtask

  task automatic wait_idle(input int limit);
    int w = 0;
    while ((exp_done.size() + exp_res.size() + exp_iss.size()) != 0 && w < limit) begin
      @(posedge clk);
      w++;
    end
    chk("run_complete", exp_done.size() + exp_res.size() + exp_iss.size(), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("overflow_flag", bus.overflow_o, exp_ovf);
    chk("underflow_flag", bus.underflow_o, exp_unf);
    chk("invalid_flag", bus.invalid_o, exp_inv);
  endtask

  initial begin
    rst = 1'b1;
    bus.start_i = 1'b0; bus.n_out_i = '0; bus.x_base_i = '0; bus.fpopmode_bit_i = 1'b0;
    bus.ovf_i = 1'b0; bus.unf_i = 1'b0; bus.inv_i = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      bus.start_i = 1'($urandom); bus.n_out_i = NW'($urandom); bus.x_base_i = XW'($urandom);
      bus.fpopmode_bit_i = 1'($urandom);
      @(negedge clk);
      chk("reset_outs", all_outs(), 0);
    end
    @(posedge clk); #1;
    rst = 1'b0; bus.start_i = 1'b0;
    repeat (5) @(posedge clk);

    start_run(1, 20, 0, s);
    wait_idle(200);
    chk("default_done_rel", last_done_cyc - s, 36);

    start_run(2, 3, 0, s);
    wait_idle(300);
    chk("wrap_done_rel", last_done_cyc - s, 68);

    ovf_at = -1; inv_at = -1; exc_mode = 1;
    start_run(1, 20, 1, s);
    ovf_at = s + 36; inv_at = s + 25;
    wait_idle(200);
    chk("fp_overflow_set", bus.overflow_o, 1);
    chk("inv_without_valid", bus.invalid_o, 0);
    exc_mode = 2;
    start_run(1, 5, 1, s);
    @(negedge clk);
    chk("start_clears_flags", {bus.overflow_o, bus.underflow_o, bus.invalid_o}, 0);
    wait_idle(200);

    ovf_at = -1; inv_at = -1; exc_mode = 1;
    start_run(1, 20, 0, s);
    ovf_at = s + 36;
    wait_idle(200);
    chk("fixed_overflow_ignored", bus.overflow_o, 0);

    exc_mode = 0;
    start_run(1, 20, 0, s);
    repeat (9) @(posedge clk); #1;
    bus.start_i = 1'b1; bus.n_out_i = 8'd3; bus.x_base_i = 6'd7;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    wait_idle(200);
    chk("restart_ignored_done_rel", last_done_cyc - s, 36);

    start_run(1, 20, 1, s);
    repeat (9) @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_iss.delete(); exp_res.delete(); exp_done.delete(); exp_yv.delete();
    busy_lo = 1; busy_hi = 0;
    @(negedge clk);
    chk("mid_reset_outs", all_outs(), 0);
    repeat (30) @(posedge clk);

    start_run(0, 9, 0, s);
    wait_idle(50);
    chk("zero_count_done_rel", last_done_cyc - s, 1);

    repeat (6) begin
      start_run($urandom_range(1, 4), $urandom_range(0, 63), 1'($urandom_range(0, 1)), s);
      wait_idle(1000);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
